// File: rtl/pc_fetch_sequencer.sv
// PC/fetch sequencer: fixed-latency imem fetch, single-instruction exec handshake, redirect/halt, display buffer.
// Optional perf counters (retired_cnt, stall_cnt) are built only when PERF_COUNTERS_EN is defined.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     PC_STEP   = 1,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     FETCH_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            result_we,
  input  logic [XLEN-1:0] result_in,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] disp_data,
  output logic            disp_valid,
  input  logic            disp_ready,
  output logic            halted,
  output logic            misalign_err,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] MASK = STEP - 1'b1;
  localparam logic [2:0]      LAT  = 3'(FETCH_LAT);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] disp_data_q, disp_data_d;
  logic            disp_valid_q, disp_valid_d;
  logic            misalign_q, misalign_d;

  logic            disp_block, exec_acc, misalign;
  logic [XLEN-1:0] pc_next;

  // A new result may not overwrite a display value that has not been consumed.
  assign disp_block = result_we & disp_valid_q & ~disp_ready;
  assign exec_acc   = (state_q == S_EXEC) & exec_done & ~stall & ~disp_block;
  assign pc_next    = redirect_en ? redirect_pc : pc_q + STEP;
  assign misalign   = redirect_en & (|(redirect_pc & MASK));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    disp_data_d   = disp_data_q;
    disp_valid_d  = disp_valid_q & ~disp_ready;
    if (exec_acc && result_we) begin
      disp_data_d  = result_in;
      disp_valid_d = 1'b1;
    end
    case (state_q)
      S_REQ: if (!stall) begin
        cnt_d   = 3'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_EXEC: if (exec_acc) begin
        instr_valid_d = 1'b0;
        if (misalign) begin
          misalign_d = 1'b1;
          state_d    = S_HALT;
        end else begin
          pc_d    = pc_next;
          state_d = halt_req ? S_HALT : S_REQ;
        end
      end
      S_HALT: if (resume) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  // Request is the REQ-state issue cycle itself; gated by rst so it reads 0 while in reset.
  assign imem_req     = rst & (state_q == S_REQ) & ~stall;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign disp_data    = disp_data_q;
  assign disp_valid   = disp_valid_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_q;

`ifdef PERF_COUNTERS_EN
  logic        exec_blk;
  logic [31:0] retired_q, stall_q;
  assign exec_blk = (state_q == S_EXEC) & exec_done & ~exec_acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (exec_acc) retired_q <= retired_q + 32'd1;
      if (exec_blk) stall_q   <= stall_q + 32'd1;
    end
  end
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Parametrised program-counter and fetch sequencer for the next-generation RISC core. It replaces the fixed single-cycle PC/fetch/display path.
- Issues fetches to an instruction memory with configurable latency and presents one instruction at a time to decode/execute.
- Applies branch/jump redirects, stall and halt/resume.
- Buffers the retired result for the display with a valid/ready handshake.

Parameters:
- XLEN, 32: PC and result width.
- PC_STEP, 1: PC increment per instruction. 1 means word-addressed; 4 means byte-addressed. Must be a power of two.
- RESET_PC, 0: PC value after reset.
- FETCH_LAT, 1: instruction-memory read latency in cycles, range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_rdata  in  32  instruction word, valid FETCH_LAT cycles after imem_req.
- instr  out  32  registered instruction for decode.
- instr_valid  out  1  instr is held for execute.
- exec_done  in  1  execute has finished instr.
- redirect_en  in  1  take redirect_pc; sampled with an accepted exec_done.
- redirect_pc  in  XLEN  branch/jump target.
- result_we  in  1  the instruction produced a result for display; sampled with exec_done.
- result_in  in  XLEN  result value.
- stall  in  1  blocks new fetch issue and exec acceptance.
- halt_req  in  1  halt after the current instruction; sampled with an accepted exec_done.
- resume  in  1  leave HALT.
- disp_data  out  XLEN  buffered result.
- disp_valid  out  1  disp_data pending.
- disp_ready  in  1  display consumes disp_data.
- halted  out  1  state==HALT.
- misalign_err  out  1  sticky error flag.
- retired_cnt  out  32  instructions retired (optional feature).
- stall_cnt  out  32  cycles with an exec_done blocked (optional feature).

Behaviour:
- Reset (rst=0, asynchronous), all registers cleared immediately:
  - pc=RESET_PC, state=REQ.
  - imem_req, instr, instr_valid, disp_data, disp_valid, misalign_err, counters = 0.
- Reset asserted mid-fetch or mid-exec abandons the operation; no partial update survives.
- States: REQ, WAIT, EXEC, HALT.
- REQ:
  - stall=1: remain in REQ, imem_req=0.
  - Otherwise: imem_req=1 for this cycle, cnt<=1, go to WAIT.
- WAIT:
  - When cnt==FETCH_LAT: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - Else cnt<=cnt+1.
  - stall is ignored here; fixed-latency data is never dropped.
  - Issue-to-instr_valid latency is FETCH_LAT+1 cycles.
- EXEC: exec_done is accepted only when all of these hold:
  - stall=0.
  - Not (result_we=1 and disp_valid=1 and disp_ready=0).
- Blocked exec_done leaves state, pc and instr unchanged (backpressure).
- On an accepted exec_done:
  - instr_valid<=0.
  - If result_we: disp_data<=result_in, disp_valid<=1.
  - Next pc = redirect_en ? redirect_pc : pc+PC_STEP, modulo 2^XLEN. Wrap-around from all-ones is legal.
  - If redirect_en and redirect_pc % PC_STEP != 0: misalign_err<=1, pc unchanged, go to HALT.
  - Else if halt_req: pc<=next pc, go to HALT.
  - Else: pc<=next pc, go to REQ.
- HALT:
  - halted=1, no fetch issued.
  - resume=1 goes to REQ with pc unchanged. Resume does not clear misalign_err; only reset does.
  - halt_req in HALT has no effect.
- Display buffer (disp_valid & disp_ready):
  - Clears disp_valid unless the same cycle accepts a new result. In that case disp_data takes the new value and disp_valid stays 1.
  - Drains in every state, including HALT.
- Simultaneous redirect_en and halt_req: the redirect is applied to pc, then HALT.
- imem_addr is combinationally equal to pc.

Optional Feature:
PERF_COUNTERS_EN
- Defined:
  - retired_cnt increments on every accepted exec_done.
  - stall_cnt increments on every EXEC cycle where exec_done=1 but is blocked.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
1. Reset release, FETCH_LAT=2, imem returns 0x00000013:
   - imem_req pulses at cycle 1 with imem_addr=0.
   - instr_valid rises at cycle 4 with instr=0x00000013.
2. Five sequential exec_done, PC_STEP=4, no redirect:
   - imem_addr sequence 0,4,8,12,16,20.
   - retired_cnt=5 (with PERF_COUNTERS_EN).
3. exec_done with redirect_en=1, redirect_pc=0x40:
   - next imem_addr=0x40.
   - Repeat with redirect_pc=0x42 and PC_STEP=4: misalign_err=1, halted=1, pc stays at the old value.
4. disp_ready=0, two retiring instructions with result_we=1 and results 7 then 9:
   - disp_data=7, and the second exec_done is blocked (stall_cnt increments).
   - Raise disp_ready: disp_data=9 and pc advances.
5. halt_req with exec_done at pc=8, PC_STEP=4:
   - halted=1, no imem_req for 10 cycles.
   - resume: imem_addr=12.
6. Assert rst during WAIT with instr_valid=0:
   - all outputs return to reset values immediately.
   - After release, first fetch at RESET_PC.
